// File: rtl/line_reader_pkg.sv
// Shared types and default geometry for the camera line reader.
// The tag travels with each FIFO read so markers are fixed when the byte is fetched.
package line_reader_pkg;

  localparam int DEF_LINE_BYTES  = 1280;
  localparam int DEF_FRAME_LINES = 720;
  localparam int DEF_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } tag_t;

  typedef struct packed {
    tag_t       tag;
    logic [7:0] data;
  } mark_t;

  // Counter width that stays legal when a dimension is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer for marked bytes.
// A synchronous clear empties it without touching the stored words.
module skid_buf2
  import line_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_i,
  input  logic       push_i,
  input  mark_t      push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output mark_t      data_o,
  output logic [1:0] count_o
);

  mark_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/line_reader.sv
// Read-side sequencer for the camera line FIFO: waits for a full line, bursts it
// through a 2-entry skid buffer with line/frame markers, and resyncs after overflow.
module line_reader
  import line_reader_pkg::*;
#(
  parameter int LINE_BYTES  = DEF_LINE_BYTES,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fifo_rready,
  input  logic [7:0]  fifo_rdata,
  input  logic        fifo_error,
  output logic        fifo_ren,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_sol,
  output logic        o_eol,
  output logic        o_sof,
  output logic        o_eof,
  output logic [10:0] o_line,
  output logic        o_resync
);

  localparam int BW = cnt_w(LINE_BYTES);
  localparam int LW = cnt_w(FRAME_LINES);
  localparam int GW = cnt_w(GAP_CYCLES);

  localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  logic          err_s1_q, err_s2_q, err_s3_q;
  logic          err_evt;
  state_e        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          low_q, low_d;
  logic          rd_q, rd_d;
  tag_t          tag_q, tag_d;

  logic          byte_last, line_last, gap_last;
  logic          skid_valid, skid_clr, skid_push, pop, credit_ok;
  logic [1:0]    skid_cnt;
  logic [2:0]    occ;
  mark_t         skid_out, push_mark;

  // fifo_error comes from the write clock; the third flop only finds the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {err_s3_q, err_s2_q, err_s1_q} <= 3'b000;
    end else begin
      {err_s3_q, err_s2_q, err_s1_q} <= {err_s2_q, err_s1_q, fifo_error};
    end
  end

  assign err_evt   = err_s2_q && !err_s3_q;
  assign byte_last = (byte_q == BYTE_LAST);
  assign line_last = (line_q == LINE_LAST);
  assign gap_last  = (gap_q == GAP_LAST);

  assign skid_clr  = err_evt || (state_q == ST_DRAIN);
  assign skid_push = rd_q && !skid_clr;
  assign push_mark = {tag_q, fifo_rdata};
  assign o_valid   = skid_valid && !skid_clr;
  assign pop       = o_valid && i_ready;

  // Held bytes plus the read in flight, net of this cycle's pop, must leave a slot.
  assign occ       = 3'(skid_cnt) + 3'(rd_q) - 3'(pop);
  assign credit_ok = (occ < 3'd2);

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    line_d   = line_q;
    gap_d    = gap_q;
    low_d    = low_q;
    tag_d    = tag_q;
    rd_d     = 1'b0;
    fifo_ren = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        byte_d = '0;
        gap_d  = '0;
        if (fifo_rready) state_d = ST_READ;
      end
      ST_READ: begin
        if (credit_ok) begin
          fifo_ren  = 1'b1;
          rd_d      = 1'b1;
          tag_d.sol = (byte_q == '0);
          tag_d.eol = byte_last;
          tag_d.sof = (byte_q == '0) && (line_q == '0);
          tag_d.eof = byte_last && line_last;
          if (byte_last) begin
            byte_d  = '0;
            state_d = ST_GAP;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          gap_d   = '0;
          line_d  = line_last ? '0 : line_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Whole lines are thrown away until the FIFO stays below a line for 2 cycles.
        fifo_ren = fifo_rready;
        if (fifo_rready) begin
          byte_d = byte_last ? '0 : byte_q + 1'b1;
          low_d  = 1'b0;
        end else if (low_q) begin
          byte_d  = '0;
          line_d  = '0;
          low_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          low_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_evt) begin
      state_d  = ST_DRAIN;
      fifo_ren = 1'b0;
      rd_d     = 1'b0;
      byte_d   = '0;
      gap_d    = '0;
      low_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      gap_q   <= '0;
      low_q   <= 1'b0;
      rd_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
      low_q   <= low_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
    end
  end

  skid_buf2 u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (skid_clr),
    .push_i      (skid_push),
    .push_data_i (push_mark),
    .pop_i       (pop),
    .valid_o     (skid_valid),
    .data_o      (skid_out),
    .count_o     (skid_cnt)
  );

  assign o_data   = skid_out.data;
  assign o_sol    = skid_out.tag.sol;
  assign o_eol    = skid_out.tag.eol;
  assign o_sof    = skid_out.tag.sof;
  assign o_eof    = skid_out.tag.eof;
  assign o_line   = 11'(line_q);
  assign o_resync = (state_q == ST_DRAIN);

endmodule

// File: doc/line_reader.md
# line_reader

Read-side sequencer for the camera line FIFO (16-bit write, 8-bit read, almost-full flag signalling one complete line available). Waits until a full line is buffered, bursts it out with `fifo_ren`, and presents a byte stream with line/frame markers to downstream consumers under valid/ready backpressure. Tracks position within the frame and resynchronises cleanly after a write-side overflow error.

## Interface
- `LINE_BYTES`, 1280: bytes read per line (640 px × 2 B)
- `FRAME_LINES`, 720: lines per frame
- `GAP_CYCLES`, 4: idle cycles enforced between line bursts
- `clk` in 1: read-side clock (same clock as the FIFO read port)
- `rstn` in 1: asynchronous, active-low reset
- `fifo_rready` in 1: FIFO almost-full flag; high = at least one full line buffered
- `fifo_rdata` in 8: FIFO read data, valid exactly 1 cycle after `fifo_ren`
- `fifo_error` in 1: overflow error from the write domain (asynchronous to `clk`)
- `fifo_ren` out 1: FIFO read enable
- `o_data` out 8: output byte
- `o_valid` out 1: `o_data` and markers valid
- `i_ready` in 1: downstream accepts when `o_valid && i_ready`
- `o_sol`, `o_eol` out 1: first / last byte of a line (qualified by `o_valid`)
- `o_sof`, `o_eof` out 1: first byte of line 0 / last byte of line `FRAME_LINES-1`
- `o_line` out 11: current line index
- `o_resync` out 1: high while discarding after an error

## Operation
- `fifo_error` passes through a 2-flop synchroniser; a rising edge of the synchronised signal is an error event.
- FSM states: IDLE, READ, GAP, DRAIN.
  - IDLE: wait for `fifo_rready`=1 → READ; byte counter cleared.
  - READ: `fifo_ren`=1 on every cycle the skid buffer has a free slot (see Timing); byte counter increments per `fifo_ren`. After the `LINE_BYTES`-th `fifo_ren` → GAP.
  - GAP: count `GAP_CYCLES`; then line counter increments (wraps `FRAME_LINES-1`→0) and → IDLE.
  - DRAIN: entered from any state on an error event. Skid buffer cleared, `o_valid` forced 0, `o_resync`=1. While `fifo_rready`=1, read and discard full lines. When `fifo_rready`=0 for 2 consecutive cycles: line counter ← 0, byte counter ← 0, → IDLE. Next emitted byte carries `o_sof`.
- Markers derive from the byte/line index attached to each byte as it enters the skid buffer: `o_sol` at byte 0, `o_eol` at byte `LINE_BYTES-1`, `o_sof` = `o_sol` on line 0, `o_eof` = `o_eol` on line `FRAME_LINES-1`.
- Error event coinciding with the last byte of a line: error wins; that byte is dropped.
- Counters are `$clog2` wide; comparisons use `LINE_BYTES-1` and `FRAME_LINES-1`; no counter exceeds its terminal value.

## Timing
- Reset values: `fifo_ren`=0, `o_valid`=0, `o_data`=0, all markers 0, `o_line`=0, `o_resync`=0, FSM=IDLE, skid empty.
- FIFO read latency is fixed at 1 cycle; the returned byte is captured into a 2-entry skid buffer.
- Credit rule: `fifo_ren` may assert only if (entries held + reads in flight) < 2 after accounting for a pop in the same cycle. This guarantees no byte loss under arbitrary `i_ready`.
- Throughput with `i_ready`=1: 1 byte/cycle; first `o_valid` 2 cycles after READ entry; a line occupies `LINE_BYTES` + `GAP_CYCLES` + 1 (IDLE) cycles minimum.
- `o_data`/markers hold stable while `o_valid && !i_ready`.
- `o_line` updates on GAP exit, after the line's last byte has entered the skid buffer.

## Structure
- Package `line_reader_pkg`: FSM state enum, default `LINE_BYTES`/`FRAME_LINES`/`GAP_CYCLES` constants, marker struct {sol, eol, sof, eof, data}.
- Sub-module `skid_buf2`: 2-entry valid/ready buffer carrying the marker struct, with synchronous clear input used by DRAIN.
- Synchroniser is inline (2 flops), not a separate module.

## Test plan
- Single line, `i_ready`=1, FIFO model preloaded: `fifo_rready` 1 → 1280 consecutive `fifo_ren`, 1280 bytes out in order, `o_sol` on byte 0, `o_eol` on byte 1279, `o_line` 0→1.
- Random `i_ready` (50%): 3 lines, output matches FIFO content exactly, no `fifo_ren` when credits exhausted, markers hold during stall.
- Frame wrap with `FRAME_LINES`=4: lines 0–3 emitted, `o_sof` on line 0 byte 0, `o_eof` on line 3 byte 1279, line 4 returns to `o_line`=0 with `o_sof`.
- Error mid-line (byte 600 of line 2): `o_valid` drops within 3 cycles, `o_resync`=1, remaining buffered lines discarded, after `fifo_rready` low ≥2 cycles next output byte has `o_sof`=1.
- Error coincident with byte 1279: byte not emitted, DRAIN entered, no `o_eol` seen.
- `rstn` asserted mid-READ: all outputs reach reset values immediately (asynchronously); after release, waits in IDLE for `fifo_rready`.
